bus_slave_mem: RTL and testbench

- Bus slave directly downstream of the write master. Consumes as_n / wr_n / address / data and returns ack_n.
- Holds a small word-addressed register memory and completes each transfer with a full four-phase handshake.
- Inserts a programmable number of wait states before acknowledging.
- Serves write cycles from the master and read cycles for later readback stages. Exposes a completed-write counter for debug/LEDs.

---
 rtl/bus_slave_mem_if.sv | 31 +++
 rtl/bus_slave_mem.sv | 114 +++++++++++
 tb/tb_bus_slave_mem.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_if.sv
// Asynchronous-style strobe/acknowledge bus between the write master and the
// register-memory slave. All signals are synchronous to the system clock.
interface bus_slave_mem_if;
  logic        as_n;
  logic        wr_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        ack_n;
  logic [31:0] data_out;

  // Four-phase handshake: master drops as_n with wr_n/address/data_in stable
  // for the sampling edge; slave drops ack_n when the access is done and
  // raises it only after seeing as_n high again. Master may abort before ack.
  modport master (
    output as_n,
    output wr_n,
    output address,
    output data_in,
    input  ack_n,
    input  data_out
  );

  modport slave (
    input  as_n,
    input  wr_n,
    input  address,
    input  data_in,
    output ack_n,
    output data_out
  );
endinterface

// File: rtl/bus_slave_mem.sv
// Word-addressed register memory behind a four-phase as_n/ack_n handshake,
// with programmable wait states and a completed-write counter.
module bus_slave_mem #(
  parameter int ADDR_BITS   = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  bus_slave_mem_if.slave      bus,
  output logic                busy,
  output logic [15:0]         wr_count,
  output logic [1:0]          o_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_LOAD = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_wcnt;
  logic                   r_wr_n;
  logic [31:0]            r_addr;
  logic [31:0]            r_data;
  logic                   r_ack_n;
  logic [31:0]            r_dout;
  logic                   r_busy;
  logic [15:0]            r_wr_count;
  logic [31:0]            r_mem [DEPTH];

  logic                   w_in_range;
  logic [ADDR_BITS-1:0]   w_idx;

  // Decode works on the latched address so late master changes are ignored.
  assign w_in_range = (r_addr[31:ADDR_BITS] == '0);
  assign w_idx      = r_addr[ADDR_BITS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_wr_n     <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
      r_ack_n    <= 1'b1;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.as_n) begin
            r_addr  <= bus.address;
            r_wr_n  <= bus.wr_n;
            r_data  <= bus.data_in;
            r_wcnt  <= WS_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.as_n) begin
            // Master withdrew the strobe before ack: drop the cycle silently.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wcnt == '0) begin
            r_ack_n <= 1'b0;
            r_state <= S_ACK;
            if (!r_wr_n) begin
              if (w_in_range) begin
                r_mem[w_idx] <= r_data;
                r_wr_count   <= r_wr_count + 16'd1;
              end
            end else begin
              r_dout <= w_in_range ? r_mem[w_idx] : 32'd0;
            end
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        S_ACK: begin
          // Held here until the strobe goes away, so one strobe = one access.
          if (bus.as_n) begin
            r_ack_n <= 1'b1;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack_n <= 1'b1;
          r_dout  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_n    = r_ack_n;
  assign bus.data_out = r_dout;
  assign busy         = r_busy;
  assign wr_count     = r_wr_count;
  assign o_state      = r_state;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: one instance with two wait states, one with none,
// compared against an array/queue model of the memory and write counter.
module tb_bus_slave_mem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_slave_mem_if bus0();
  bus_slave_mem_if bus2();

  logic        busy0, busy2;
  logic [15:0] wrc0, wrc2;
  logic [1:0]  st0, st2;

  bus_slave_mem #(.ADDR_BITS(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0),
    .busy(busy0), .wr_count(wrc0), .o_state(st0)
  );

  bus_slave_mem #(.ADDR_BITS(4), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2),
    .busy(busy2), .wr_count(wrc2), .o_state(st2)
  );

  int checks = 0;
  int errors = 0;

  // Index 0 models the zero-wait instance, index 1 the two-wait instance.
  logic [31:0] exp_mem [2][16];
  int          exp_cnt [2];
  logic [31:0] exp_q[$];

  function automatic int ws_of(input int sel);
    return (sel != 0) ? 2 : 0;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel != 0) ? bus2.ack_n : bus0.ack_n;
  endfunction

  function automatic logic [31:0] get_dout(input int sel);
    return (sel != 0) ? bus2.data_out : bus0.data_out;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy2 : busy0;
  endfunction

  function automatic logic [15:0] get_cnt(input int sel);
    return (sel != 0) ? wrc2 : wrc0;
  endfunction

  task automatic drive_bus(input int sel, input logic as_n, input logic wr_n,
                           input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      bus2.as_n = as_n; bus2.wr_n = wr_n; bus2.address = a; bus2.data_in = d;
    end else begin
      bus0.as_n = as_n; bus0.wr_n = wr_n; bus0.address = a; bus0.data_in = d;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      exp_cnt[s] = 0;
      for (int i = 0; i < 16; i++) exp_mem[s][i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_xfer(input int sel, input logic wr_n,
                            input logic [31:0] a, input logic [31:0] d);
    if (!wr_n) begin
      if (a < 32'd16) begin
        exp_mem[sel][a] = d;
        exp_cnt[sel] = (exp_cnt[sel] + 1) % 65536;
      end
    end else begin
      exp_q.push_back((a < 32'd16) ? exp_mem[sel][a] : 32'd0);
    end
  endtask

  // Full transfer starting just after a negedge; returns what was observed.
  // n = posedges from the first strobe-sampling edge up to and including the
  // edge after which ack_n was seen low.
  task automatic xfer(input int sel, input logic wr_n, input logic [31:0] a,
                      input logic [31:0] d, output int n, output logic [31:0] rd,
                      output logic busy_mid, output logic ack_post,
                      output logic [31:0] dout_post, output logic busy_post,
                      output bit to);
    logic [31:0] junk_a, junk_d;
    model_xfer(sel, wr_n, a, d);
    drive_bus(sel, 1'b0, wr_n, a, d);
    n = 0; to = 1'b1; busy_mid = 1'b0;
    junk_a = $urandom; junk_d = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        busy_mid = get_busy(sel);
        drive_bus(sel, 1'b0, ~wr_n, junk_a, junk_d);
      end
      if (get_ack(sel) == 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    rd = get_dout(sel);
    drive_bus(sel, 1'b1, ~wr_n, junk_a, junk_d);
    @(negedge clk);
    ack_post  = get_ack(sel);
    dout_post = get_dout(sel);
    busy_post = get_busy(sel);
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    drive_bus(0, 1'b1, 1'b1, '0, '0);
    drive_bus(1, 1'b1, 1'b1, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++; if (get_ack(s) !== 1'b1) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 1", s, get_ack(s)); end
      checks++; if (get_dout(s) !== 32'd0) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0", s, get_dout(s)); end
      checks++; if (get_busy(s) !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, get_busy(s)); end
      checks++; if (get_cnt(s) !== 16'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d want 0", s, get_cnt(s)); end
    end
    checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st2); end
  endtask

  task automatic test_write_basic();
    int n; logic [31:0] rd, dp; logic bm, ap, bp; bit to;
    for (int a = 0; a < 3; a++) begin
      xfer(1, 1'b0, 32'(a), 32'h0000_00C8, n, rd, bm, ap, dp, bp, to);
      checks++; if (to || n != ws_of(1) + 2) begin errors++; $display("FAIL wr_latency[%0d]: got %0d edges (timeout %0d) want %0d", a, n, to, ws_of(1) + 2); end
      checks++; if (bm !== 1'b1) begin errors++; $display("FAIL wr_busy_mid[%0d]: got %b want 1", a, bm); end
      checks++; if (ap !== 1'b1 || bp !== 1'b0) begin errors++; $display("FAIL wr_release[%0d]: got ack %b busy %b want 1 0", a, ap, bp); end
    end
    checks++; if (wrc2 !== 16'(exp_cnt[1])) begin errors++; $display("FAIL wr_count_basic: got %0d want %0d", wrc2, exp_cnt[1]); end
  endtask

  task automatic test_read();
    int n; logic [31:0] rd, dp, want; logic bm, ap, bp; bit to;
    for (int a = 1; a < 3; a++) begin
      xfer(1, 1'b1, 32'(a), $urandom, n, rd, bm, ap, dp, bp, to);
      want = exp_q.pop_front();
      checks++; if (to || rd !== want) begin errors++; $display("FAIL rd_data[%0d]: got %h want %h", a, rd, want); end
      checks++; if (dp !== 32'd0 || ap !== 1'b1) begin errors++; $display("FAIL rd_release[%0d]: got dout %h ack %b want 0 1", a, dp, ap); end
    end
    checks++; if (wrc2 !== 16'(exp_cnt[1])) begin errors++; $display("FAIL rd_cnt: got %0d want %0d", wrc2, exp_cnt[1]); end
  endtask

  task automatic test_abort();
    int n; logic [31:0] rd, dp, want; logic bm, ap, bp; bit to;
    drive_bus(1, 1'b0, 1'b0, 32'd2, 32'h1234_5678);
    @(negedge clk);
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b want 1", busy2); end
    drive_bus(1, 1'b1, 1'b0, 32'd2, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus2.ack_n !== 1'b1) begin errors++; $display("FAIL abort_ack[%0d]: got %b want 1", i, bus2.ack_n); end
    end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy2); end
    checks++; if (wrc2 !== 16'(exp_cnt[1])) begin errors++; $display("FAIL abort_cnt: got %0d want %0d", wrc2, exp_cnt[1]); end
    xfer(1, 1'b1, 32'd2, '0, n, rd, bm, ap, dp, bp, to);
    want = exp_q.pop_front();
    checks++; if (to || rd !== want) begin errors++; $display("FAIL abort_mem: got %h want %h", rd, want); end
  endtask

  task automatic test_out_of_range();
    int n; logic [31:0] rd, dp, want; logic bm, ap, bp; bit to;
    xfer(1, 1'b0, 32'h10, 32'hDEAD_BEEF, n, rd, bm, ap, dp, bp, to);
    checks++; if (to || n != ws_of(1) + 2 || ap !== 1'b1) begin errors++; $display("FAIL oor_wr_hs: got %0d edges ack %b want %0d 1", n, ap, ws_of(1) + 2); end
    checks++; if (wrc2 !== 16'(exp_cnt[1])) begin errors++; $display("FAIL oor_cnt: got %0d want %0d", wrc2, exp_cnt[1]); end
    xfer(1, 1'b1, 32'h0, '0, n, rd, bm, ap, dp, bp, to);
    want = exp_q.pop_front();
    checks++; if (to || rd !== want) begin errors++; $display("FAIL oor_mem0: got %h want %h", rd, want); end
    xfer(1, 1'b1, 32'h10, '0, n, rd, bm, ap, dp, bp, to);
    want = exp_q.pop_front();
    checks++; if (to || rd !== want) begin errors++; $display("FAIL oor_rd: got %h want %h", rd, want); end
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] rd, dp, want; logic bm, ap, bp; bit to;
    bit seen = 1'b0;
    drive_bus(1, 1'b0, 1'b1, 32'd0, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.ack_n == 1'b0) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_ack_seen: got ack 1 want 0"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus2.ack_n !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL rstmid_async: got ack %b busy %b want 1 0", bus2.ack_n, busy2); end
    checks++; if (wrc2 !== 16'd0 || wrc0 !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d %0d want 0 0", wrc2, wrc0); end
    checks++; if (bus2.data_out !== 32'd0) begin errors++; $display("FAIL rstmid_dout: got %h want 0", bus2.data_out); end
    model_clear();
    drive_bus(1, 1'b1, 1'b1, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 1'b1, 32'd0, '0, n, rd, bm, ap, dp, bp, to);
    want = exp_q.pop_front();
    checks++; if (to || rd !== want) begin errors++; $display("FAIL rstmid_mem: got %h want %h", rd, want); end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] rd, dp, want; logic bm, ap, bp; bit to;
    for (int a = 0; a < 20; a++) begin
      xfer(0, 1'b0, 32'(a), $urandom, n, rd, bm, ap, dp, bp, to);
      checks++; if (to || n != ws_of(0) + 2) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d edges want %0d", a, n, ws_of(0) + 2); end
    end
    checks++; if (wrc0 !== 16'(exp_cnt[0])) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", wrc0, exp_cnt[0]); end
    for (int a = 14; a < 17; a++) begin
      xfer(0, 1'b1, 32'(a), '0, n, rd, bm, ap, dp, bp, to);
      want = exp_q.pop_front();
      checks++; if (to || rd !== want) begin errors++; $display("FAIL b2b_rd[%0d]: got %h want %h", a, rd, want); end
    end
  endtask

  task automatic test_random();
    int n, sel; logic [31:0] a, d, rd, dp, want; logic wr_n, bm, ap, bp; bit to;
    for (int i = 0; i < 80; i++) begin
      sel  = $urandom_range(0, 1);
      wr_n = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom_range(0, 15);
        2:       a = $urandom_range(16, 31);
        default: a = $urandom | 32'h0000_0100;
      endcase
      d = $urandom;
      xfer(sel, wr_n, a, d, n, rd, bm, ap, dp, bp, to);
      checks++; if (to || n != ws_of(sel) + 2) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d edges want %0d", i, n, ws_of(sel) + 2); end
      if (wr_n) begin
        want = exp_q.pop_front();
        checks++; if (rd !== want) begin errors++; $display("FAIL rnd_rd[%0d] addr %h: got %h want %h", i, a, rd, want); end
      end
      checks++; if (get_cnt(sel) !== 16'(exp_cnt[sel])) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, get_cnt(sel), exp_cnt[sel]); end
      checks++; if (ap !== 1'b1 || dp !== 32'd0 || bp !== 1'b0) begin errors++; $display("FAIL rnd_release[%0d]: got ack %b dout %h busy %b", i, ap, dp, bp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read();
    test_abort();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
